// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a small FIFO of fetch packets that absorbs
// decode stalls and is emptied by a pipeline flush.
module inst_queue #(
  parameter int DATA_W = 69,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_bus,
  output logic              in_allowin,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_bus,
  input  logic              out_allowin,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_s, pop_s;

  // Allowin depends only on registered occupancy, keeping decode stalls off the fetch path.
  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == CNT_ZERO);
  assign in_allowin = ~full;
  assign out_valid  = ~empty & ~flush;
  assign out_bus    = mem_q[rd_ptr_q];
  assign count      = count_q;

  assign push_s = in_valid & in_allowin & ~flush;
  assign pop_s  = out_valid & out_allowin;

  // Next-state for pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and packet storage; the array is cleared on reset so out_bus is never X.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_bus;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: table of per-cycle vectors with
// hand-derived expectations plus a packet scoreboard for FIFO ordering.
module tb_inst_queue;

  localparam int DATA_W = 69;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_allowin;
  logic [DATA_W-1:0] in_bus;
  logic              in_allowin, out_valid, full, empty;
  logic [DATA_W-1:0] out_bus;
  logic [PTR_W:0]    count;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb [$];

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic        oa;
    logic        fl;
    logic        ov;
    logic        ia;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [28];

  inst_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_bus(in_bus), .in_allowin(in_allowin),
    .out_valid(out_valid), .out_bus(out_bus), .out_allowin(out_allowin),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk_pkt(input logic [31:0] pc);
    return {pc[6:2], pc ^ 32'hdeadbeef, pc};
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, update scoreboard, check count after edge.
  task automatic step(input logic iv, input logic [31:0] pc, input logic oa, input logic fl,
                      input logic rst, input logic exp_ov, input logic exp_ia, input logic [2:0] exp_cnt);
    logic m_push, m_pop;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; out_allowin = oa; in_bus = mk_pkt(pc);
    #1;
    chk("out_valid", {68'd0, out_valid}, {68'd0, exp_ov});
    chk("in_allowin", {68'd0, in_allowin}, {68'd0, exp_ia});
    chk("full", {68'd0, full}, {68'd0, sb.size() == DEPTH});
    chk("empty", {68'd0, empty}, {68'd0, sb.size() == 0});
    m_push = iv && (sb.size() < DEPTH) && !fl && !rst;
    m_pop  = (sb.size() > 0) && oa && !fl && !rst;
    if (m_pop) begin
      chk("out_bus", out_bus, sb[0]);
      void'(sb.pop_front());
    end
    if (rst || fl) sb.delete();
    else if (m_push) sb.push_back(mk_pkt(pc));
    @(posedge clk);
    #1;
    chk("count", {66'd0, count}, {66'd0, exp_cnt});
  endtask

  initial begin
    // iv, pc, oa, fl, exp out_valid, exp in_allowin, exp count after edge
    tbl[0]  = '{1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[1]  = '{1'b1, 32'h1c000004, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[2]  = '{1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[3]  = '{1'b1, 32'h1c00000c, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    tbl[4]  = '{1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
    tbl[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
    tbl[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    tbl[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[10] = '{1'b1, 32'h1c000020, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[11] = '{1'b1, 32'h1c000024, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[12] = '{1'b1, 32'h1c000028, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[13] = '{1'b1, 32'h1c00002c, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    tbl[14] = '{1'b1, 32'h1c000030, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
    tbl[15] = '{1'b1, 32'h1c000030, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    tbl[16] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3};
    tbl[17] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[18] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    tbl[19] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[20] = '{1'b1, 32'h1c000040, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[21] = '{1'b1, 32'h1c000044, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[22] = '{1'b1, 32'h1c000048, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[23] = '{1'b1, 32'h1c000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[24] = '{1'b1, 32'h1c000200, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[25] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
    tbl[26] = '{1'b1, 32'h1c000300, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[27] = '{1'b1, 32'h1c000304, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0; in_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_count", {66'd0, count}, 69'd0);
    chk("rst_empty", {68'd0, empty}, 69'd1);
    chk("rst_full", {68'd0, full}, 69'd0);
    chk("rst_in_allowin", {68'd0, in_allowin}, 69'd1);
    chk("rst_out_valid", {68'd0, out_valid}, 69'd0);
    chk("rst_out_bus", out_bus, 69'd0);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].iv, tbl[i].pc, tbl[i].oa, tbl[i].fl, 1'b0, tbl[i].ov, tbl[i].ia, tbl[i].cnt);
    end

    // Mid-operation reset together with flush.
    step(1'b1, 32'h1c000500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    step(1'b1, 32'h1c000504, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
    step(1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;
    #1;
    chk("midrst_out_valid", {68'd0, out_valid}, 69'd0);
    chk("midrst_out_bus", out_bus, 69'd0);

    // Streaming through several pointer wraps.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 32'h1c001000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, (i != 0), 1'b1, 3'd1);
    end
    step(1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    chk("final_sb_empty", {37'd0, 32'(sb.size())}, 69'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling instruction queue between the fetch stage and the decode stage.
- Accepts fetch packets (exception flags, instruction, pc) from fetch using a valid/allowin handshake and presents them to decode in FIFO order.
- Absorbs decode stalls so fetch keeps issuing requests while decode is blocked.
- Discards all queued packets on a pipeline flush: writeback exception/ertn, or branch redirect from decode.

Parameters:
- DATA_W, 69: packet width, {adef, tlbr, pif, ppi, pme, inst[31:0], pc[31:0]}.
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- PTR_W, 2: log2(DEPTH); the count is PTR_W+1 bits wide.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drop all queued packets; driven by wb_flush OR decode branch-taken.
- in_valid  in  1  fetch has a packet this cycle (fs_to_ds_valid).
- in_bus  in  DATA_W  fetch packet.
- in_allowin  out  1  queue can accept a packet; drives the fetch-side ds_allowin.
- out_valid  out  1  head packet is valid for decode.
- out_bus  out  DATA_W  head packet.
- out_allowin  in  1  decode accepts the head this cycle.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: DEPTH x DATA_W register array, wr_ptr and rd_ptr (PTR_W bits, wrap modulo DEPTH), and count.
- push = in_valid & in_allowin & ~flush.
- pop = out_valid & out_allowin.
- in_allowin = ~full. It has no combinational dependence on out_allowin, which avoids a decode-to-fetch timing path.
  - When full, a same-cycle pop does not enable a push; the push waits one cycle.
- out_valid = ~empty & ~flush.
- out_bus = mem[rd_ptr], read combinationally. It is don't-care when out_valid=0, but must not be X after reset: the array resets to 0.
- Latency: a packet pushed in cycle N is visible on out_valid/out_bus in cycle N+1 at the earliest. There is no bypass path.
- Push: mem[wr_ptr] <= in_bus; wr_ptr <= wr_ptr+1.
- Pop: rd_ptr <= rd_ptr+1.
- Count: +1 on push only, -1 on pop only, unchanged on push+pop (only possible when not full and not empty).
- Wrap: a pointer at DEPTH-1 increments to 0. Full/empty are derived from count, never from pointer equality.
- Flush has priority over everything:
  - next cycle wr_ptr=0, rd_ptr=0, count=0;
  - the push in the flush cycle is dropped;
  - out_valid=0 in the flush cycle, so no pop occurs.
  - The array contents need not be cleared.
- Flush while empty: no effect other than blocking any push that cycle.
- Back-to-back flushes: the queue stays empty. in_allowin=1 throughout because the queue is not full.
- Reset (synchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, array=0.
  - Outputs after reset: in_allowin=1, out_valid=0, full=0, empty=1, count=0, out_bus=0.
  - Reset asserted mid-operation discards all entries at the next edge, identically to a flush.
  - Reset has priority over flush.
- Invariant: exceptions carried in packet flag bits pass through unmodified. The queue never interprets packet contents.
- No state machine beyond the pointers and count. All outputs other than out_bus come from registered state, or from registered state gated by flush.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release → count=0, empty=1, in_allowin=1, out_valid=0, out_bus=0.
- Fill and drain, DEPTH=4: push pc 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c with out_allowin=0.
  - full=1 and in_allowin=0 after the 4th push; a 5th in_valid is not accepted.
  - Then out_allowin=1 for 4 cycles → pcs appear in order, one per cycle; empty=1 after.
- Streaming: in_valid=1 and out_allowin=1 continuously from empty with pc incrementing by 4.
  - out_valid rises one cycle after the first push; count stays 1.
  - pcs arrive in order through at least 3 pointer wraps.
- Full plus pop: queue full, in_valid=1, out_allowin=1 → pop occurs, push blocked that cycle (count 4→3); push accepted next cycle (count back to 4).
- Flush with simultaneous push: queue holds 3 entries; flush=1 with in_valid=1 (pc 0x1c000100).
  - out_valid=0 in that cycle; next cycle count=0, empty=1.
  - The next pushed packet (pc 0x1c000200) is the first one output.
- Mid-operation reset: 2 entries queued, reset=1 and flush=1 together for 1 cycle → next cycle count=0, out_valid=0, out_bus=0.
